// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - pipeline and data-memory signal bundle for mem_access_unit
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] inAddress;
    logic [31:0]       inWriteData;
    logic              inMemRead;
    logic              inMemWrite;
    logic [1:0]        inSize;
    logic              inSignExt;
    logic [31:0]       inMemReadData;

    logic [ADDR_W-1:0] outMemAddress;
    logic [31:0]       outMemWriteData;
    logic              outMemRead;
    logic              outMemWrite;
    logic [31:0]       outReadData;
    logic              outStall;
    logic              outDone;
    logic              outMisaligned;

    modport slave (
        input  inAddress, inWriteData, inMemRead, inMemWrite, inSize, inSignExt, inMemReadData,
        output outMemAddress, outMemWriteData, outMemRead, outMemWrite,
        output outReadData, outStall, outDone, outMisaligned
    );

    modport master (
        output inAddress, inWriteData, inMemRead, inMemWrite, inSize, inSignExt, inMemReadData,
        input  outMemAddress, outMemWriteData, outMemRead, outMemWrite,
        input  outReadData, outStall, outDone, outMisaligned
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage byte/half/word sequencer over a word-only data memory
// Define MEM_MISALIGN_TRAP_EN to flag and suppress misaligned half/word accesses.
module mem_access_unit #(
    parameter int ADDR_W    = 32,
    parameter int MEM_IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t               state, stateNext;
    logic [MEM_IDX_W+1:0] capAddr;
    logic [MEM_IDX_W+1:0] idxAddr;
    logic [31:0]          capData;
    logic [31:0]          capWord;
    logic [31:0]          readData;
    logic [1:0]           capSize;
    logic                 capSign;
    logic                 capWrite;
    logic                 capMis;
    logic                 req;
    logic                 misNow;

    assign req = bus.inMemRead ^ bus.inMemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misNow = 1'b0;
        if (bus.inSize[1])
            misNow = (bus.inAddress[1:0] != 2'b00);
        else if (bus.inSize[0])
            misNow = bus.inAddress[0];
    end
`else
    assign misNow = 1'b0;
`endif

    // Size 1x is a word, 01 a half, 00 a byte; half lanes look only at addr[1].
    function automatic logic [31:0] loadExtend(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] a, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        if (sz[1])
            return w;
        else if (sz[0])
            return {{16{sx & h[15]}}, h};
        else
            return {{24{sx & b[7]}}, b};
    endfunction

    function automatic logic [31:0] storeMerge(input logic [31:0] w, input logic [31:0] d,
                                               input logic [1:0] sz, input logic [1:0] a);
        logic [31:0] r;
        r = w;
        if (sz[1])
            r = d;
        else if (sz[0])
            r[{a[1], 4'b0000} +: 16] = d[15:0];
        else
            r[{a, 3'b000} +: 8] = d[7:0];
        return r;
    endfunction

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (misNow)
                        stateNext = DONE;
                    else if (bus.inMemWrite && bus.inSize[1])
                        stateNext = WR;
                    else
                        stateNext = RD;
                end
            end
            RD:      stateNext = capWrite ? WR : DONE;
            WR:      stateNext = DONE;
            default: stateNext = IDLE;
        endcase
    end

    assign idxAddr = (state == IDLE) ? bus.inAddress[MEM_IDX_W+1:0] : capAddr;

    always_comb begin
        bus.outMemAddress                  = '0;
        bus.outMemAddress[MEM_IDX_W-1:0]   = idxAddr[MEM_IDX_W+1:2];
        bus.outMemWriteData                = storeMerge(capWord, capData, capSize, capAddr[1:0]);
        bus.outMemRead                     = (state == RD);
        bus.outMemWrite                    = (state == WR);
        bus.outReadData                    = readData;
        bus.outStall                       = req && (state != DONE);
        bus.outDone                        = (state == DONE);
        bus.outMisaligned                  = (state == DONE) && capMis;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            capAddr  <= '0;
            capData  <= '0;
            capWord  <= '0;
            capSize  <= '0;
            capSign  <= 1'b0;
            capWrite <= 1'b0;
            capMis   <= 1'b0;
            readData <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (req) begin
                        capAddr  <= bus.inAddress[MEM_IDX_W+1:0];
                        capData  <= bus.inWriteData;
                        capSize  <= bus.inSize;
                        capSign  <= bus.inSignExt;
                        capWrite <= bus.inMemWrite;
                        capMis   <= misNow;
                        if (misNow && bus.inMemRead)
                            readData <= '0;
                    end
                end
                RD: begin
                    capWord <= bus.inMemReadData;
                    if (!capWrite)
                        readData <= loadExtend(bus.inMemReadData, capSize, capAddr[1:0], capSign);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the EX/MEM pipeline register and the word-only data memory in the MEM stage.
- Converts byte, halfword and word loads/stores into word-indexed memory accesses.
- Sub-word stores use read-modify-write. Loads return sign- or zero-extended data.
- A small FSM sequences each access and stalls the pipeline until it completes.

Parameters:
- ADDR_W, 32, byte address width from the EX/MEM register.
- MEM_IDX_W, 5, word-index width driven to the data memory (32 words).

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- inAddress  input  32  byte address (ALU result).
- inWriteData  input  32  store data (rt value), right-justified.
- inMemRead  input  1  load request.
- inMemWrite  input  1  store request.
- inSize  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
- inSignExt  input  1  1 = sign-extend sub-word loads, 0 = zero-extend.
- inMemReadData  input  32  word returned by the data memory (combinational read).
- outMemAddress  output  32  word index = inAddress >> 2, upper bits zero above MEM_IDX_W.
- outMemWriteData  output  32  full word written to memory.
- outMemRead  output  1  memory read strobe.
- outMemWrite  output  1  memory write strobe.
- outReadData  output  32  extended load result to MEM/WB.
- outStall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- outDone  output  1  one-cycle pulse: access complete this cycle.
- outMisaligned  output  1  valid with outDone.

Behaviour:
- Request definition:
  - req = inMemRead XOR inMemWrite.
  - Both or neither asserted = no request; the unit stays in IDLE and drives no strobes.
- States: IDLE, RD, WR, DONE.
  - IDLE, load or sub-word store -> RD.
  - IDLE, word store -> WR.
  - IDLE, misaligned (feature enabled) -> DONE.
  - RD, load -> DONE.
  - RD, sub-word store -> WR.
  - WR -> DONE.
  - DONE -> IDLE unconditionally.
- Request capture: address, data, size, sign and direction are latched on leaving IDLE. The upstream stall holds the inputs stable anyway.
- Stall:
  - outStall = req && state != DONE (combinational).
  - In DONE, outStall = 0, so the pipeline advances on that edge.
  - The next request is sampled in IDLE on the following cycle.
- Latency, measured from the request appearing in IDLE, with the done cycle counted as the last cycle:
  - Word load: 3 cycles (IDLE, RD, DONE).
  - Word store: 3 cycles (IDLE, WR, DONE).
  - Sub-word load: 3 cycles.
  - Sub-word store: 4 cycles (IDLE, RD, WR, DONE).
- RD state:
  - outMemRead = 1, outMemWrite = 0.
  - inMemReadData is captured into an internal word register at the edge.
- WR state:
  - outMemWrite = 1, outMemRead = 0.
  - Sub-word stores: outMemWriteData = captured word with the selected lane replaced.
  - Word stores: outMemWriteData = inWriteData.
- Strobes: outMemRead and outMemWrite are never both 1. Both are 0 in IDLE and DONE.
- Lanes are little-endian:
  - Byte lane = addr[1:0], bits 8*lane+7 .. 8*lane.
  - Half lane = addr[1], bits 16*lane+15 .. 16*lane.
- Load result:
  - Selected lane extended per inSignExt; the word is passed through unchanged.
  - outReadData is registered and holds until the next load's DONE.
  - outReadData is not modified by stores.
- Misaligned (feature enabled): half with addr[0]=1, or word with addr[1:0]!=0.
  - No memory strobe is issued; the FSM goes directly to DONE.
  - outMisaligned = 1 with outDone; outReadData = 0.
- Reset values: state = IDLE; outReadData = 0; outDone = 0; outMisaligned = 0; captured word = 0; strobes = 0.
- Reset mid-operation: the FSM returns to IDLE at that edge. If reset hits in RD of a read-modify-write, the write is abandoned and memory is unchanged.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: misalignment is detected and flagged as described, and the access is suppressed.
- Undefined:
  - Low address bits are force-aligned: half uses addr[1] only, word ignores addr[1:0].
  - The access always proceeds.
  - outMisaligned is tied to 0.

Test Plan:
- Word load, addr 0x4, mem[1]=0x00000002 -> outMemRead high 1 cycle at index 1; DONE at cycle 3 with outReadData=0x00000002; outStall high for cycles 1-2.
- Byte store 0xAB at addr 0x5, mem[1]=0x00000002 -> RD then WR; mem[1]=0x0000AB02; 4-cycle latency; outReadData unchanged.
- Byte load, signed, addr 0x5 after the previous store -> 0xFFFFFFAB. Same access unsigned -> 0x000000AB.
- Half load, addr 0x3:
  - Macro defined: outMisaligned=1, outReadData=0, no strobes.
  - Macro undefined: lane 1 of mem[0] is returned.
- Reset asserted in RD of a half store to addr 0x0 (mem[0]=0x00000001) -> FSM in IDLE next cycle; outMemWrite never asserted; mem[0] still 0x00000001.
- inMemRead=inMemWrite=1 -> stays in IDLE, no strobes, outStall=0, outDone=0.
